// File: rtl/sc_pkg.sv
// Shared helpers and types for the stochastic-computing bitstream decoder.
package sc_pkg;

  typedef enum logic {SC_UNIPOLAR, SC_BIPOLAR} sc_polarity_t;

  function automatic int sc_window_len(input int window_bits);
    return 1 << window_bits;
  endfunction

  // Two extra bits: one to hold the full count N, one for the bipolar sign.
  function automatic int sc_out_width(input int window_bits);
    return window_bits + 2;
  endfunction

endpackage

// File: rtl/sc_window_counter.sv
// Counts ones over a window of 2^WINDOW_BITS qualified bits; strobes done on the closing bit.
module sc_window_counter
  import sc_pkg::*;
#(
  parameter int WINDOW_BITS = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 x,
  input  logic                 x_valid,
  input  logic                 clr,
  output logic [WINDOW_BITS:0] cnt_final,
  output logic                 done
);

  logic [WINDOW_BITS-1:0] idx;
  logic [WINDOW_BITS:0]   cnt;
  logic                   last_bit;

  assign last_bit  = (idx == '1);
  // The closing bit is folded in here so the result includes it.
  assign cnt_final = cnt + (WINDOW_BITS+1)'(x);
  assign done      = x_valid && !clr && last_bit;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      idx <= '0;
      cnt <= '0;
    end else if (clr) begin
      idx <= '0;
      cnt <= '0;
    end else if (x_valid) begin
      idx <= idx + WINDOW_BITS'(1);
      cnt <= last_bit ? '0 : cnt_final;
    end
  end

endmodule

// File: rtl/sc_bitstream_decoder.sv
// Stochastic bitstream to binary decoder with a single-entry valid/ready output register.
// Define SC_BITSTREAM_DECODER_BIPOLAR_EN for bipolar (2*cnt - N) decoding; default is unipolar.
module sc_bitstream_decoder
  import sc_pkg::*;
#(
  parameter  int WINDOW_BITS = 8,
  localparam int OUT_W       = sc_out_width(WINDOW_BITS)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             x,
  input  logic             x_valid,
  input  logic             clr,
  output logic [OUT_W-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             overrun
);

  localparam int N = sc_window_len(WINDOW_BITS);

`ifdef SC_BITSTREAM_DECODER_BIPOLAR_EN
  localparam sc_polarity_t POLARITY = SC_BIPOLAR;
`else
  localparam sc_polarity_t POLARITY = SC_UNIPOLAR;
`endif

  logic [WINDOW_BITS:0] cnt_final;
  logic                 done;
  logic [OUT_W-1:0]     y_next;

  sc_window_counter #(
    .WINDOW_BITS (WINDOW_BITS)
  ) u_window_counter (
    .CLK       (CLK),
    .nRST      (nRST),
    .x         (x),
    .x_valid   (x_valid),
    .clr       (clr),
    .cnt_final (cnt_final),
    .done      (done)
  );

  // NOTE: give every always_comb output a default first so no path can infer a latch.
  always_comb begin
    y_next = '0;
    if (POLARITY == SC_BIPOLAR) y_next = {cnt_final, 1'b0} - OUT_W'(N);
    else                        y_next = {1'b0, cnt_final};
  end

  // A new result always wins the register; overrun flags that the old one was never taken.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      y       <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= done && y_valid && !y_ready;
      if (done) begin
        y       <= y_next;
        y_valid <= 1'b1;
      end else if (y_valid && y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// Directed scoreboard bench for sc_bitstream_decoder at WINDOW_BITS=3 (N=8, OUT_W=5).
module tb_sc_bitstream_decoder;
  import sc_pkg::*;

  localparam int WB = 3;
  localparam int N  = 8;
  localparam int OW = 5;

`ifdef SC_BITSTREAM_DECODER_BIPOLAR_EN
  localparam sc_polarity_t POL = SC_BIPOLAR;
`else
  localparam sc_polarity_t POL = SC_UNIPOLAR;
`endif

  logic          CLK = 1'b0;
  logic          nRST;
  logic          x;
  logic          x_valid;
  logic          clr;
  logic          y_ready;
  logic [OW-1:0] y;
  logic          y_valid;
  logic          overrun;

  sc_bitstream_decoder #(
    .WINDOW_BITS (WB)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .x       (x),
    .x_valid (x_valid),
    .clr     (clr),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .overrun (overrun)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  int            m_idx;
  int            m_cnt;
  logic          m_yv;
  logic          m_ovr;
  logic [OW-1:0] m_y;
  logic [OW-1:0] sb_q[$];
  int            ovr_pulses;

  function automatic logic [OW-1:0] golden(input int c);
    if (POL == SC_BIPOLAR) return OW'(2 * c - N);
    return OW'(c);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    nRST = 1'b0; x = 1'b1; x_valid = 1'b1; clr = 1'b0; y_ready = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    m_idx = 0; m_cnt = 0; m_yv = 1'b0; m_ovr = 1'b0; m_y = '0;
    sb_q.delete();
    check("rst_y", 32'(y), 32'd0);
    check("rst_y_valid", 32'(y_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
  endtask

  // Drive one cycle, advance the reference model, then compare at the falling edge.
  task automatic step(input logic xi, input logic vi, input logic ci, input logic ri);
    logic done;
    int   fin;
    x = xi; x_valid = vi; clr = ci; y_ready = ri;
    done = vi && !ci && (m_idx == N - 1);
    fin  = m_cnt + int'(xi);
    if (ci) begin
      m_idx = 0; m_cnt = 0;
    end else if (vi) begin
      m_cnt = (m_idx == N - 1) ? 0 : fin;
      m_idx = (m_idx + 1) % N;
    end
    m_ovr = done && m_yv && !ri;
    if (done) begin
      m_y  = golden(fin);
      m_yv = 1'b1;
      sb_q.push_back(m_y);
    end else if (m_yv && ri) begin
      m_yv = 1'b0;
    end
    @(posedge CLK);
    @(negedge CLK);
    if (overrun) ovr_pulses++;
    check("y_valid", 32'(y_valid), 32'(m_yv));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("y_hold", 32'(y), 32'(m_y));
    if (sb_q.size() != 0) check("y_result", 32'(y), 32'(sb_q.pop_front()));
  endtask

  task automatic run_window(input logic [7:0] bits, input logic ri);
    for (int i = 7; i >= 0; i--) step(bits[i], 1'b1, 1'b0, ri);
  endtask

  initial begin
    nRST = 1'b0; x = 1'b0; x_valid = 1'b0; clr = 1'b0; y_ready = 1'b0;
    ovr_pulses = 0;
    do_reset();

    // Basic window: four ones, result appears the cycle after the eighth bit.
    run_window(8'b1011_0010, 1'b1);
    check("basic_y", 32'(y), 32'(golden(4)));
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Extremes back-to-back with no idle cycle.
    run_window(8'hFF, 1'b1);
    check("ones_y", 32'(y), 32'(golden(8)));
    run_window(8'h00, 1'b1);
    check("zeros_y", 32'(y), 32'(golden(0)));
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // x_valid toggling: invalid cycles carry x=1 and must be ignored.
    for (int i = 0; i < 15; i++) step(1'b1, (i % 2) == 0, 1'b0, 1'b1);
    check("toggle_y", 32'(y), 32'(golden(8)));
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Two windows without acceptance: second overwrites and pulses overrun once.
    ovr_pulses = 0;
    run_window(8'b1010_1000, 1'b0);
    run_window(8'b1110_1110, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_y", 32'(y), 32'(golden(6)));
    check("ovr_pulses", 32'(ovr_pulses), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_drained", 32'(y_valid), 32'd0);

    // clr on the fifth valid bit discards the partial window.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    run_window(8'b0000_0011, 1'b1);
    check("clr5_y", 32'(y), 32'(golden(2)));
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // clr on the would-be completion edge produces no result.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_last_no_result", 32'(y_valid), 32'd0);
    run_window(8'b0100_0000, 1'b1);
    check("clr_last_y", 32'(y), 32'(golden(1)));
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-window, then a fresh window.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    run_window(8'b0111_0000, 1'b1);
    check("post_rst_y", 32'(y), 32'(golden(3)));
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Completion on the same edge the previous result is accepted.
    ovr_pulses = 0;
    run_window(8'b1100_0000, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("sim_y", 32'(y), 32'(golden(7)));
    check("sim_y_valid", 32'(y_valid), 32'd1);
    check("sim_no_overrun", 32'(ovr_pulses), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
